// File: rtl/seq_divider_16_pkg.sv
// Shared arithmetic definitions for the sequential divider: FSM encoding,
// default operand width and the divide-by-zero quotient.
package seq_divider_16_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic [15:0] DIV0_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_16_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
interface seq_divider_16_if
  import seq_divider_16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_trial_sub_17.sv
// 17-bit trial subtraction a - m, computed as a + ~m + 1 with four 4-bit
// carry-lookahead blocks and a single top bit. borrow is the inverted carry-out.
module div_trial_sub_17 (
  input  logic [16:0] a,
  input  logic [16:0] m,
  output logic [16:0] diff,
  output logic        borrow
);

  // 4-bit CLA block: all internal carries from generate/propagate terms.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

  logic [16:0] mb;
  logic [16:0] sum;
  logic        cout;

  assign mb = ~m;

  // Carry-in of 1 completes the two's complement; block carries chain upward.
  always_comb begin
    logic       carry;
    logic [4:0] blk;
    sum   = '0;
    carry = 1'b1;
    blk   = '0;
    for (int i = 0; i < 4; i++) begin
      blk          = cla4(a[4*i +: 4], mb[4*i +: 4], carry);
      sum[4*i +: 4] = blk[3:0];
      carry        = blk[4];
    end
    sum[16] = a[16] ^ mb[16] ^ carry;
    cout    = (a[16] & mb[16]) | ((a[16] ^ mb[16]) & carry);
  end

  assign diff   = sum;
  assign borrow = ~cout;

endmodule

// File: rtl/seq_divider_16.sv
// Multi-cycle unsigned restoring divider with a start/done handshake.
// One quotient bit per clock; divide-by-zero finishes in a single cycle.
module seq_divider_16
  import seq_divider_16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  seq_divider_16_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic             dbz_r;

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   m;

  logic [WIDTH:0]   acc_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             accept;

  // A new request is only taken when no division is in flight.
  assign accept = bus.start && ((state == IDLE) || (state == DONE));

  assign acc_sh = {acc[WIDTH-1:0], q[WIDTH-1]};

  div_trial_sub_17 u_trial (
    .a      (acc_sh),
    .m      (m),
    .diff   (diff),
    .borrow (borrow)
  );

  // Restore on borrow: keep the shifted remainder and shift in a 0 bit.
  assign acc_nxt = borrow ? acc_sh : diff;
  assign q_nxt   = {q[WIDTH-2:0], ~borrow};

  // Working registers: loaded on accept, iterated in RUN, otherwise held.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc <= '0;
      q   <= bus.dividend;
      m   <= {1'b0, bus.divisor};
    end else if (state == RUN) begin
      acc <= acc_nxt;
      q   <= q_nxt;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
      dbz_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
              quot_r <= DIV0_QUOTIENT;
              rem_r  <= bus.dividend;
              dbz_r  <= 1'b1;
            end else begin
              state  <= RUN;
              busy_r <= 1'b1;
              count  <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          count <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            quot_r <= q_nxt;
            rem_r  <= acc_nxt[WIDTH-1:0];
            dbz_r  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: doc/seq_divider_16.md
Name: seq_divider_16

Overview:
- Multi-cycle 16-bit unsigned restoring divider: the inverse of the CLA adder datapath.
- Every iteration is a 17-bit trial subtraction done as add-with-complement (carry-in = 1), reusing the team's carry-lookahead style.
- Sits beside the 16-bit adder in the arithmetic unit and is driven by a start/done handshake.

Parameters:
- WIDTH, 16, operand width; quotient/remainder width; iteration count.
- CNT_W, 5, iteration counter width (must hold the value WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  WIDTH  numerator; captured on the accepted start.
- divisor  input  WIDTH  denominator; captured on the accepted start.
- busy  output  1  high while iterating (RUN).
- done  output  1  single-cycle pulse when the result becomes valid.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  flag for the current result; held with quotient/remainder.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1, divisor!=0:
  - load A=0 (17b), Q=dividend, M={0,divisor}, count=0;
  - next state RUN; busy=1 from the next cycle.
- IDLE, start=1, divisor=0:
  - skip RUN and go to DONE next edge;
  - quotient=16'hFFFF, remainder=dividend, div_by_zero=1.
- RUN, each edge:
  - shift {A,Q} left by 1;
  - T = A_shifted + ~M + 1 (17b);
  - T[16]=0 (no borrow): A=T, Q[0]=1; otherwise A unchanged, Q[0]=0;
  - count++.
- RUN, on the edge where count reaches WIDTH-1: latch quotient=Q, remainder=A[15:0], div_by_zero=0; go to DONE; busy=0.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted exactly as from IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- Latency, start sampled to done high:
  - normal operation: WIDTH+1 = 17 cycles;
  - divide-by-zero: 1 cycle.
- start while in RUN: ignored; operands are not resampled.
- Outputs are stable from done until the next accepted start.
  - Between accept and the next done, quotient/remainder keep their previous values; internal A/Q are not exposed.
- Reset mid-RUN: immediate abort; all outputs return to reset values; no done pulse.
- Result identity (divisor!=0): dividend == quotient*divisor + remainder, and remainder < divisor.

Decomposition:
- Shared arithmetic package holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the WIDTH default (16);
  - the divide-by-zero quotient constant 16'hFFFF.
- One sub-module: div_trial_sub_17.
  - Combinational 17-bit A + ~M + 1, built from the existing 4-bit CLA block/lookahead structure.
  - Outputs the difference and the borrow (inverted carry-out).
- Control FSM, counter and shift registers stay in seq_divider_16.

Test Plan:
- Reset, then dividend=100, divisor=7, start 1 cycle -> busy for 16 cycles; done at cycle 17; quotient=14, remainder=2, div_by_zero=0.
- dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=1234, divisor=0 -> done 1 cycle after start; quotient=16'hFFFF, remainder=1234, div_by_zero=1; busy never asserted.
- Start 60000/255; pulse start with 9/3 at RUN cycle 5 -> second request ignored; result quotient=235, remainder=75.
- Start 1000/10; assert rst at RUN cycle 8 -> all outputs 0 immediately; no done. After release, 1000/10 -> quotient=100, remainder=0.
- Hold start=1 across DONE with 81/9 then 17/4 -> second operation accepted in the DONE cycle; done pulses 17 cycles apart; results 9/0 then 4/1.
